// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-level definitions used by the data-memory arbiter slice.
//   DMEM_DATA_WIDTH / DMEM_ADDR_WIDTH : data memory geometry (512 x 32)
//   arb_state_t                       : ownership FSM encoding, which doubles
//                                       as the 'owner' output encoding
//   PORT_CPU / PORT_DBG               : requester indices
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_ADDR_WIDTH = 9;

    // Encoding is chosen so the state value is directly the owner code.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Ownership state reached by a locked grant to the given port.
    function automatic arb_state_t own_state(input logic port);
        return (port == PORT_DBG) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester's handshake bundle towards the data-memory arbiter.
//   req    : access request, held until gnt
//   we     : 1 = write, 0 = read (stable while req)
//   lock   : keep ownership after this grant
//   addr   : word address (stable while req)
//   wdata  : write data (stable while req)
//   gnt    : combinational accept, this cycle
//   rvalid : one-cycle pulse, read data valid
//   rdata  : read data, holds its last value while rvalid is low
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) ();

    logic                  req;
    logic                  we;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, 2^ADDR_WIDTH words of DATA_WIDTH bits.
//   clk   : clock, posedge
//   we    : write enable, mem[addr] <= wdata at the edge
//   re    : read enable, rdata <= mem[addr] at the edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds while re is low
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module dmem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Array write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates the 512x32 data memory between port 0 (CPU load/store) and
// port 1 (debug/loader). At most one access is granted per cycle; read data
// returns one cycle after the grant. A locked grant gives the port exclusive
// ownership until it drops lock, enabling atomic read-modify-write.
//   clk   : clock, posedge
//   reset : synchronous, active-high
//   p0    : port 0 (PORT_CPU) handshake, slave modport
//   p1    : port 1 (PORT_DBG) handshake, slave modport
//   owner : registered, 0 = none, 1 = port 0 locked, 2 = port 1 locked
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin contention
// resolution in the unowned state; otherwise port 0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        p0,
    dmem_arbiter_if.slave        p1,
    output logic [1:0]           owner
);

    arb_state_t            state_r;
    arb_state_t            state_nxt_s;
    logic                  prefer_s;
    logic                  idle_gnt0_s;
    logic                  idle_gnt1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;
    logic                  rd_valid_r;
    logic                  rd_tag_r;
    logic                  rvalid0_s;
    logic                  rvalid1_s;
    logic [DATA_WIDTH-1:0] hold0_r;
    logic [DATA_WIDTH-1:0] hold1_r;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_gnt_r;

    // Last-granted port; reset value makes port 0 preferred first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= PORT_DBG;
        end else if (gnt0_s) begin
            last_gnt_r <= PORT_CPU;
        end else if (gnt1_s) begin
            last_gnt_r <= PORT_DBG;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign prefer_s = ~last_gnt_r;
`else
    assign prefer_s = PORT_CPU;
`endif

    // Unowned-state policy: single requester wins, contention goes to prefer_s.
    always_comb begin
        idle_gnt0_s = 1'b0;
        idle_gnt1_s = 1'b0;
        if (p0.req && p1.req) begin
            idle_gnt0_s = (prefer_s == PORT_CPU);
            idle_gnt1_s = (prefer_s == PORT_DBG);
        end else begin
            idle_gnt0_s = p0.req;
            idle_gnt1_s = p1.req;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a grant decides by its lock bit; without a grant the
    // owner keeps the state only while it still asserts lock.
    always_comb begin
        state_nxt_s = state_r;
        if (gnt0_s) begin
            state_nxt_s = p0.lock ? own_state(PORT_CPU) : IDLE;
        end else if (gnt1_s) begin
            state_nxt_s = p1.lock ? own_state(PORT_DBG) : IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = IDLE;
                OWN0:    state_nxt_s = p0.lock ? OWN0 : IDLE;
                OWN1:    state_nxt_s = p1.lock ? OWN1 : IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM outputs (grants). The owner is served first; once it drops lock
    // and is not requesting, the other port is arbitrated in the same cycle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    gnt0_s = idle_gnt0_s;
                    gnt1_s = idle_gnt1_s;
                end
                OWN0: begin
                    if (p0.req) begin
                        gnt0_s = 1'b1;
                    end else if (!p0.lock) begin
                        gnt1_s = idle_gnt1_s;
                    end else begin
                        gnt0_s = 1'b0;
                        gnt1_s = 1'b0;
                    end
                end
                OWN1: begin
                    if (p1.req) begin
                        gnt1_s = 1'b1;
                    end else if (!p1.lock) begin
                        gnt0_s = idle_gnt0_s;
                    end else begin
                        gnt0_s = 1'b0;
                        gnt1_s = 1'b0;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Steer the granted port onto the single RAM port.
    always_comb begin
        ram_we_s    = (gnt0_s && p0.we) || (gnt1_s && p1.we);
        ram_re_s    = (gnt0_s && !p0.we) || (gnt1_s && !p1.we);
        ram_addr_s  = p0.addr;
        ram_wdata_s = p0.wdata;
        if (gnt1_s) begin
            ram_addr_s  = p1.addr;
            ram_wdata_s = p1.wdata;
        end else begin
            ram_addr_s  = p0.addr;
            ram_wdata_s = p0.wdata;
        end
    end

    dmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Read-return tracking: valid pulse plus which port issued the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_tag_r   <= PORT_CPU;
        end else begin
            rd_valid_r <= ram_re_s;
            rd_tag_r   <= ram_re_s ? gnt1_s : rd_tag_r;
        end
    end

    assign rvalid0_s = rd_valid_r && (rd_tag_r == PORT_CPU);
    assign rvalid1_s = rd_valid_r && (rd_tag_r == PORT_DBG);

    // Per-port capture of delivered read data, so each port's rdata holds
    // even when the shared RAM output register moves on for the other port.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold0_r <= {DATA_WIDTH{1'b0}};
            hold1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            hold0_r <= rvalid0_s ? ram_rdata_s : hold0_r;
            hold1_r <= rvalid1_s ? ram_rdata_s : hold1_r;
        end
    end

    assign p0.gnt    = gnt0_s;
    assign p1.gnt    = gnt1_s;
    assign p0.rvalid = rvalid0_s;
    assign p1.rvalid = rvalid1_s;
    assign p0.rdata  = rvalid0_s ? ram_rdata_s : hold0_r;
    assign p1.rdata  = rvalid1_s ? ram_rdata_s : hold1_r;
    assign owner     = state_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter. Inputs are driven 1 time
// unit after each rising edge; combinational grants are sampled after they
// settle and registered outputs after the following edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    logic [1:0] owner;

    int errors;
    int checks;

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0_if),
        .p1    (p1_if),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic lock,
                          input logic [8:0] addr, input logic [31:0] wdata);
        p0_if.req   = req;
        p0_if.we    = we;
        p0_if.lock  = lock;
        p0_if.addr  = addr;
        p0_if.wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lock,
                          input logic [8:0] addr, input logic [31:0] wdata);
        p1_if.req   = req;
        p1_if.we    = we;
        p1_if.lock  = lock;
        p1_if.addr  = addr;
        p1_if.wdata = wdata;
    endtask

    logic exp0;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);

        // Reset held 3 cycles with both requests high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt0", 32'(p0_if.gnt), 32'd0);
            chk("rst_gnt1", 32'(p1_if.gnt), 32'd0);
            chk("rst_rvalid0", 32'(p0_if.rvalid), 32'd0);
            chk("rst_rvalid1", 32'(p1_if.rvalid), 32'd0);
            chk("rst_owner", 32'(owner), 32'd0);
        end
        chk("rst_rdata0", p0_if.rdata, 32'h0);
        chk("rst_rdata1", p1_if.rdata, 32'h0);

        // Release: port 0 is granted first.
        reset = 1'b0;
        #1;
        chk("first_gnt0", 32'(p0_if.gnt), 32'd1);
        chk("first_gnt1", 32'(p1_if.gnt), 32'd0);
        tick();
        chk("first_rvalid0", 32'(p0_if.rvalid), 32'd1);
        drive0(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        // Port 1 still requesting: it is served now.
        #1;
        chk("first_gnt1b", 32'(p1_if.gnt), 32'd1);
        tick();
        chk("first_rvalid1", 32'(p1_if.rvalid), 32'd1);
        chk("first_rvalid0_end", 32'(p0_if.rvalid), 32'd0);

        // Port 1 write 0xDEADBEEF to 0x1FF, then read it back.
        drive1(1'b1, 1'b1, 1'b0, 9'h1FF, 32'hDEADBEEF);
        #1;
        chk("p1_wr_gnt", 32'(p1_if.gnt), 32'd1);
        tick();
        chk("p1_wr_rvalid", 32'(p1_if.rvalid), 32'd0);
        drive1(1'b1, 1'b0, 1'b0, 9'h1FF, 32'h0);
        #1;
        chk("p1_rd_gnt", 32'(p1_if.gnt), 32'd1);
        tick();
        chk("p1_rd_rvalid", 32'(p1_if.rvalid), 32'd1);
        chk("p1_rd_data", p1_if.rdata, 32'hDEADBEEF);
        drive1(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        tick();
        chk("p1_rvalid_pulse", 32'(p1_if.rvalid), 32'd0);
        chk("p1_rdata_hold", p1_if.rdata, 32'hDEADBEEF);

        // Preload addr 10 (port 0) and addr 11 (port 1).
        drive0(1'b1, 1'b1, 1'b0, 9'd10, 32'hA5A50010);
        tick();
        drive0(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
        drive1(1'b1, 1'b1, 1'b0, 9'd11, 32'hB1B10011);
        tick();
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);

        // Both ports read continuously for 4 cycles.
        drive0(1'b1, 1'b0, 1'b0, 9'd10, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 9'd11, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp0 = ((i % 2) == 0);
`else
            exp0 = 1'b1;
`endif
            #1;
            chk("cont_gnt0", 32'(p0_if.gnt), 32'(exp0));
            chk("cont_gnt1", 32'(p1_if.gnt), 32'(!exp0));
            tick();
            chk("cont_rvalid0", 32'(p0_if.rvalid), 32'(exp0));
            chk("cont_rvalid1", 32'(p1_if.rvalid), 32'(!exp0));
            if (exp0) begin
                chk("cont_rdata0", p0_if.rdata, 32'hA5A50010);
            end else begin
                chk("cont_rdata1", p1_if.rdata, 32'hB1B10011);
            end
        end
        drive0(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);

        // Preload addr 5 from port 1 (leaves port 1 as last granted).
        drive1(1'b1, 1'b1, 1'b0, 9'd5, 32'h00000055);
        tick();
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);

        // Port 0 locked read of addr 5 while port 1 requests.
        drive0(1'b1, 1'b0, 1'b1, 9'd5, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 9'd11, 32'h0);
        #1;
        chk("lk_rd_gnt0", 32'(p0_if.gnt), 32'd1);
        chk("lk_rd_gnt1", 32'(p1_if.gnt), 32'd0);
        chk("lk_rd_owner", 32'(owner), 32'd0);
        tick();
        chk("lk_owner", 32'(owner), 32'd1);
        chk("lk_rvalid0", 32'(p0_if.rvalid), 32'd1);
        chk("lk_rdata0", p0_if.rdata, 32'h00000055);
        // Unlocked write closes the sequence; port 1 still stalls.
        drive0(1'b1, 1'b1, 1'b0, 9'd5, 32'h00000077);
        #1;
        chk("lk_wr_gnt0", 32'(p0_if.gnt), 32'd1);
        chk("lk_wr_gnt1", 32'(p1_if.gnt), 32'd0);
        tick();
        chk("unlk_owner", 32'(owner), 32'd0);
        chk("lk_wr_rvalid0", 32'(p0_if.rvalid), 32'd0);
        drive0(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
        #1;
        chk("after_gnt1", 32'(p1_if.gnt), 32'd1);
        tick();
        chk("after_rvalid1", 32'(p1_if.rvalid), 32'd1);
        chk("after_rdata1", p1_if.rdata, 32'hB1B10011);
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);

        // Port 0 locks, then idles with lock held: port 1 must stall until
        // lock drops, then is granted in that same cycle.
        drive0(1'b1, 1'b0, 1'b1, 9'd5, 32'h0);
        #1;
        chk("lk2_gnt0", 32'(p0_if.gnt), 32'd1);
        tick();
        chk("lk2_rdata0", p0_if.rdata, 32'h00000077);
        chk("lk2_owner", 32'(owner), 32'd1);
        drive0(1'b0, 1'b0, 1'b1, 9'd0, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 9'h1FF, 32'h0);
        #1;
        chk("lk2_stall_gnt1", 32'(p1_if.gnt), 32'd0);
        tick();
        chk("lk2_owner_held", 32'(owner), 32'd1);
        p0_if.lock = 1'b0;
        #1;
        chk("lk2_drop_gnt1", 32'(p1_if.gnt), 32'd1);
        tick();
        chk("lk2_drop_owner", 32'(owner), 32'd0);
        chk("lk2_rvalid1", 32'(p1_if.rvalid), 32'd1);
        chk("lk2_rdata1", p1_if.rdata, 32'hDEADBEEF);
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);

        // Preload addr 7 with 0, then reset during port 1's write to it.
        drive0(1'b1, 1'b1, 1'b0, 9'd7, 32'h0);
        tick();
        drive0(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
        drive1(1'b1, 1'b1, 1'b0, 9'd7, 32'h12345678);
        reset = 1'b1;
        #1;
        chk("rstwr_gnt1", 32'(p1_if.gnt), 32'd0);
        tick();
        reset = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
        chk("rstwr_rvalid1", 32'(p1_if.rvalid), 32'd0);
        chk("rstwr_rdata1", p1_if.rdata, 32'h0);
        chk("rstwr_owner", 32'(owner), 32'd0);
        drive1(1'b1, 1'b0, 1'b0, 9'd7, 32'h0);
        #1;
        chk("rd7_gnt1", 32'(p1_if.gnt), 32'd1);
        tick();
        chk("rd7_rvalid1", 32'(p1_if.rvalid), 32'd1);
        chk("rd7_rdata1", p1_if.rdata, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 9'd0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
